// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcode constants,
// FSM state encoding, instruction classes and ALU operation selects.
package multicycle_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_LOAD,
      CLS_STORE,
      CLS_RTYPE,
      CLS_BRANCH,
      CLS_IALU,
      CLS_ILLEGAL
   } cls_t;

   // Map a raw opcode onto the instruction class the sequencer cares about.
   function automatic cls_t classify(input logic [6:0] op);
      cls_t c;
      case (op)
         OP_LOAD:   c = CLS_LOAD;
         OP_STORE:  c = CLS_STORE;
         OP_RTYPE:  c = CLS_RTYPE;
         OP_BRANCH: c = CLS_BRANCH;
         OP_IALU:   c = CLS_IALU;
         default:   c = CLS_ILLEGAL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Wait-state timer for memory handshakes. Counts cycles spent waiting for a
// ready and flags expiry on the cycle the count would reach MEM_TIMEOUT.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] count;

   // Count waiting cycles; a state change restarts the count from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run && (count != LAST)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = run && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the non-pipelined RV32 datapath. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, owns PC/IR/regfile write
// timing, stalls on memory wait states and halts on bad opcodes or timeouts.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_sel,
   output logic             regwrite,
   output logic             memtoreg,
   output logic             alusrc,
   output logic [1:0]       aluop,
   output logic             halted,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret
);

   state_t     state, state_next;
   cls_t       cls, cls_next;
   logic       waiting;
   logic       expired;
   logic       timeout_hit;
   logic       clear_timer;
   logic       op_alusrc;
   logic [1:0] op_aluop;

   assign waiting = ((state == S_FETCH) && !imem_ready) ||
                    ((state == S_MEM)   && !dmem_ready);

   assign clear_timer = (state_next != state);

   assign op_alusrc = (cls == CLS_LOAD) || (cls == CLS_STORE) || (cls == CLS_IALU);
   assign op_aluop  = (cls == CLS_RTYPE)  ? ALUOP_FUNCT :
                      (cls == CLS_BRANCH) ? ALUOP_SUB   : ALUOP_ADD;

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear_timer),
      .run    (waiting),
      .expired(expired)
   );

   // State and latched instruction class.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cls   <= CLS_ILLEGAL;
      end else begin
         state <= state_next;
         cls   <= cls_next;
      end
   end

   // Next-state selection and per-state datapath strobes.
   always_comb begin
      state_next  = state;
      cls_next    = cls;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_sel      = 1'b0;
      regwrite    = 1'b0;
      memtoreg    = 1'b0;
      alusrc      = 1'b0;
      aluop       = ALUOP_ADD;
      halted      = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: begin
            state_next = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write   = 1'b1;
               state_next = S_DECODE;
            end else if (expired) begin
               timeout_hit = 1'b1;
               state_next  = S_HALT;
            end
         end
         S_DECODE: begin
            cls_next = classify(opcode);
            if (cls_next == CLS_ILLEGAL) begin
               state_next = S_HALT;
            end else begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            alusrc = op_alusrc;
            aluop  = op_aluop;
            case (cls)
               CLS_LOAD, CLS_STORE: state_next = S_MEM;
               CLS_RTYPE, CLS_IALU: state_next = S_WB;
               CLS_BRANCH: begin
                  pc_write   = 1'b1;
                  pc_sel     = zero;
                  state_next = S_FETCH;
               end
               default: state_next = S_HALT;
            endcase
         end
         S_MEM: begin
            alusrc   = op_alusrc;
            aluop    = op_aluop;
            dmem_req = 1'b1;
            dmem_we  = (cls == CLS_STORE);
            if (dmem_ready) begin
               if (cls == CLS_STORE) begin
                  pc_write   = 1'b1;
                  state_next = S_FETCH;
               end else begin
                  state_next = S_WB;
               end
            end else if (expired) begin
               timeout_hit = 1'b1;
               state_next  = S_HALT;
            end
         end
         S_WB: begin
            regwrite   = 1'b1;
            memtoreg   = (cls == CLS_LOAD);
            pc_write   = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_next = S_HALT;
         end
      endcase
   end

   // Retired-instruction counter; every retirement is marked by a PC update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret <= '0;
      end else if (pc_write) begin
         instret <= instret + CNT_W'(1);
      end
   end

   // Sticky record that the halt came from a memory timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_err <= 1'b0;
      end else if (timeout_hit) begin
         bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each issued instruction pushes its
// expected retirement/halt into a queue; a negedge monitor pops on events.
module tb_multicycle_ctrl;

   localparam int TO = 4;
   localparam int CW = 4;

   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] RT   = 7'b0110011;
   localparam logic [6:0] BEQ  = 7'b1100011;
   localparam logic [6:0] IALU = 7'b0010011;

   logic          clk;
   logic          rst_n;
   logic [6:0]    opcode;
   logic          zero;
   logic          imem_ready;
   logic          dmem_ready;
   logic          imem_req;
   logic          dmem_req;
   logic          dmem_we;
   logic          ir_write;
   logic          pc_write;
   logic          pc_sel;
   logic          regwrite;
   logic          memtoreg;
   logic          alusrc;
   logic [1:0]    aluop;
   logic          halted;
   logic          bus_err;
   logic [CW-1:0] instret;

   typedef struct {
      bit            isHalt;
      bit            busErr;
      int            lat;
      int            irw;
      bit            regwrite;
      bit            memtoreg;
      bit            pcSel;
      bit            isStore;
      bit            aluPrev;
      bit            alusrc;
      logic [1:0]    aluop;
      logic [CW-1:0] instretBefore;
   } exp_t;

   exp_t          expQ[$];
   int            errors = 0;
   int            checks = 0;
   logic [CW-1:0] modelInstret;

   int            cyc;
   int            irw;
   logic          prevImemReq;
   logic          prevHalted;
   logic          prevAlusrc;
   logic [1:0]    prevAluop;

   multicycle_ctrl #(
      .MEM_TIMEOUT(TO),
      .CNT_W      (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .zero      (zero),
      .imem_ready(imem_ready),
      .dmem_ready(dmem_ready),
      .imem_req  (imem_req),
      .dmem_req  (dmem_req),
      .dmem_we   (dmem_we),
      .ir_write  (ir_write),
      .pc_write  (pc_write),
      .pc_sel    (pc_sel),
      .regwrite  (regwrite),
      .memtoreg  (memtoreg),
      .alusrc    (alusrc),
      .aluop     (aluop),
      .halted    (halted),
      .bus_err   (bus_err),
      .instret   (instret)
   );

   // Free-running core clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
      end
   endtask

   function automatic int pickWait();
      int r;
      r = $urandom_range(0, 31);
      if (r < 28) return r % 3;
      else if (r < 30) return TO - 1;
      else return TO + (r % 2);
   endfunction

   // Watchdog so a stuck handshake can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Monitor: pops an expectation on each retirement or halt and checks it.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         cyc         = 0;
         irw         = 0;
         prevImemReq = 1'b0;
         prevHalted  = 1'b0;
         prevAlusrc  = 1'b0;
         prevAluop   = 2'b00;
      end else begin
         if (imem_req && !prevImemReq) begin
            cyc = 1;
            irw = 0;
         end else begin
            cyc++;
         end
         if (ir_write) irw++;
         checkOutput("excl_ir_write", ir_write && (regwrite || pc_write || dmem_we), 0);
         checkOutput("excl_regwrite_dmem_we", regwrite && dmem_we, 0);
         if (halted) checkOutput("halt_no_request", imem_req || dmem_req, 0);
         if (dmem_req) begin
            if (expQ.size() == 0) begin
               checkOutput("dmem_req_unexpected", dmem_req, 0);
            end else begin
               checkOutput("mem_dmem_we", dmem_we, expQ[0].isStore);
               checkOutput("mem_alusrc", alusrc, 1);
               checkOutput("mem_aluop", aluop, 0);
            end
         end
         if (pc_write) begin
            if (expQ.size() == 0) begin
               checkOutput("retire_unexpected", pc_write, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("retire_not_halt", e.isHalt, 0);
               checkOutput("retire_latency", cyc, e.lat);
               checkOutput("retire_ir_writes", irw, e.irw);
               checkOutput("retire_regwrite", regwrite, e.regwrite);
               checkOutput("retire_memtoreg", memtoreg, e.memtoreg);
               checkOutput("retire_pc_sel", pc_sel, e.pcSel);
               checkOutput("retire_instret", instret, e.instretBefore);
               if (e.aluPrev) begin
                  checkOutput("exec_aluop", prevAluop, e.aluop);
                  checkOutput("exec_alusrc", prevAlusrc, e.alusrc);
               end else begin
                  checkOutput("exec_aluop", aluop, e.aluop);
                  checkOutput("exec_alusrc", alusrc, e.alusrc);
               end
            end
         end
         if (halted && !prevHalted) begin
            if (expQ.size() == 0) begin
               checkOutput("halt_unexpected", halted, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("halt_expected", e.isHalt, 1);
               checkOutput("halt_bus_err", bus_err, e.busErr);
               checkOutput("halt_latency", cyc, e.lat);
               checkOutput("halt_ir_writes", irw, e.irw);
            end
         end
         prevImemReq = imem_req;
         prevHalted  = halted;
         prevAlusrc  = alusrc;
         prevAluop   = aluop;
      end
   end

   task automatic releaseReset();
      @(posedge clk);
      #1;
      expQ.delete();
      modelInstret = '0;
      rst_n = 1'b1;
   endtask

   task automatic applyReset(input bit expectEmpty);
      rst_n      = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      #2;
      if (expectEmpty) checkOutput("queue_drained", expQ.size(), 0);
      checkOutput("rst_imem_req", imem_req, 0);
      checkOutput("rst_dmem_req", dmem_req, 0);
      checkOutput("rst_dmem_we", dmem_we, 0);
      checkOutput("rst_ir_write", ir_write, 0);
      checkOutput("rst_pc_write", pc_write, 0);
      checkOutput("rst_regwrite", regwrite, 0);
      checkOutput("rst_aluop", aluop, 0);
      checkOutput("rst_halted", halted, 0);
      checkOutput("rst_bus_err", bus_err, 0);
      checkOutput("rst_instret", instret, 0);
      releaseReset();
   endtask

   task automatic waitReq(input bit sel, output bit ok);
      int n;
      n = 0;
      while (((sel ? dmem_req : imem_req) == 1'b0) && (n < 20)) begin
         imem_ready = 1'($urandom_range(0, 1));
         dmem_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         n++;
      end
      ok = sel ? dmem_req : imem_req;
      checkOutput(sel ? "dmem_req_wait" : "imem_req_wait", ok, 1);
   endtask

   task automatic serve(input bit sel, input int w);
      int c;
      bit r;
      c = 0;
      forever begin
         r = (c == w);
         if (sel) begin
            dmem_ready = r;
            imem_ready = 1'($urandom_range(0, 1));
         end else begin
            imem_ready = r;
            dmem_ready = 1'($urandom_range(0, 1));
         end
         @(posedge clk);
         #1;
         c++;
         if (r || (c >= TO)) break;
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
   endtask

   task automatic applyStimulus(input logic [6:0] op, input int wi, input int wd, input bit z);
      exp_t e;
      bit isLoad, isStore, isR, isBr, isI, illegal, memOp, ok;
      isLoad  = (op == LW);
      isStore = (op == SW);
      isR     = (op == RT);
      isBr    = (op == BEQ);
      isI     = (op == IALU);
      illegal = !(isLoad || isStore || isR || isBr || isI);
      memOp   = isLoad || isStore;
      e = '{default: '0};
      e.isStore = isStore;
      if (wi >= TO) begin
         e.isHalt = 1'b1;
         e.busErr = 1'b1;
         e.lat    = TO + 1;
         e.irw    = 0;
      end else if (illegal) begin
         e.isHalt = 1'b1;
         e.lat    = wi + 3;
         e.irw    = 1;
      end else if (memOp && (wd >= TO)) begin
         e.isHalt = 1'b1;
         e.busErr = 1'b1;
         e.lat    = wi + 4 + TO;
         e.irw    = 1;
      end else begin
         e.irw = 1;
         if (isBr) e.lat = wi + 3;
         else if (isLoad) e.lat = wi + wd + 5;
         else if (isStore) e.lat = wi + wd + 4;
         else e.lat = wi + 4;
         e.regwrite      = isLoad || isR || isI;
         e.memtoreg      = isLoad;
         e.pcSel         = isBr && z;
         e.alusrc        = memOp || isI;
         e.aluop         = isR ? 2'b10 : (isBr ? 2'b01 : 2'b00);
         e.aluPrev       = isLoad || isR || isI;
         e.instretBefore = modelInstret;
         modelInstret    = modelInstret + 1'b1;
      end
      waitReq(1'b0, ok);
      if (!ok) begin
         applyReset(1'b0);
         return;
      end
      opcode = op;
      zero   = z;
      expQ.push_back(e);
      serve(1'b0, wi);
      if ((wi < TO) && !illegal && memOp) begin
         waitReq(1'b1, ok);
         if (!ok) begin
            applyReset(1'b0);
            return;
         end
         serve(1'b1, wd);
      end
      if (e.isHalt) begin
         repeat (6) begin
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
         end
         checkOutput("halt_held", halted, 1);
         checkOutput("halt_bus_err_held", bus_err, e.busErr);
         applyReset(1'b1);
      end
   endtask

   task automatic resetMidFetch();
      bit ok;
      waitReq(1'b0, ok);
      opcode     = RT;
      imem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midfetch_imem_req", imem_req, 0);
      checkOutput("midfetch_ir_write", ir_write, 0);
      checkOutput("midfetch_instret", instret, 0);
      releaseReset();
   endtask

   task automatic resetMidMem();
      exp_t e;
      bit ok;
      e = '{default: '0};
      e.isStore = 1'b1;
      waitReq(1'b0, ok);
      opcode = SW;
      zero   = 1'b0;
      expQ.push_back(e);
      serve(1'b0, 0);
      waitReq(1'b1, ok);
      checkOutput("midmem_we_before", dmem_we, 1);
      dmem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midmem_dmem_req", dmem_req, 0);
      checkOutput("midmem_dmem_we", dmem_we, 0);
      checkOutput("midmem_pc_write", pc_write, 0);
      releaseReset();
   endtask

   // Directed scenarios first, then a randomized instruction stream.
   initial begin
      int r;
      logic [6:0] op;
      rst_n        = 1'b0;
      opcode       = 7'd0;
      zero         = 1'b0;
      imem_ready   = 1'b0;
      dmem_ready   = 1'b0;
      modelInstret = '0;
      @(posedge clk);
      #1;
      applyReset(1'b0);

      applyStimulus(RT, 0, 0, 1'b0);
      applyStimulus(LW, 0, 3, 1'b0);
      applyStimulus(BEQ, 0, 0, 1'b1);
      applyStimulus(BEQ, 0, 0, 1'b0);
      applyStimulus(SW, 0, 0, 1'b0);
      applyStimulus(IALU, 1, 1, 1'b0);
      applyStimulus(7'b1111111, 0, 0, 1'b0);
      applyStimulus(RT, TO, 0, 1'b0);
      applyStimulus(RT, TO - 1, 0, 1'b0);
      applyStimulus(LW, 0, TO, 1'b0);
      applyStimulus(SW, 0, TO - 1, 1'b0);
      resetMidFetch();
      resetMidMem();

      for (int i = 0; i < 18; i++) begin
         applyStimulus((i % 2 == 0) ? RT : IALU, 0, 0, 1'b0);
      end

      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 39);
         if (r < 8) op = LW;
         else if (r < 16) op = SW;
         else if (r < 24) op = RT;
         else if (r < 32) op = BEQ;
         else if (r < 39) op = IALU;
         else begin
            op = 7'($urandom_range(0, 127));
            if ((op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == IALU)) op = 7'b1111111;
         end
         applyStimulus(op, pickWait(), pickWait(), 1'($urandom_range(0, 1)));
      end

      applyStimulus(7'b1111111, 0, 0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("final_queue_empty", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
